crc8_frame_ctrl: RTL and testbench



---
 rtl/crc8_frame_pkg.sv | 18 +
 rtl/crc_8.sv | 44 ++++
 rtl/crc8_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_crc8_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_frame_pkg.sv
// Shared definitions for the CRC-8 frame sequencer.
//   FRAME_BYTES      payload bytes collected per frame
//   WORD_W           width of the packed word fed to crc_8
//   FRAME_OUT_BYTES  bytes streamed downstream per frame (payload + CRC)
//   state_e          sequencer states
package crc8_frame_pkg;

  localparam int unsigned FRAME_BYTES     = 10;
  localparam int unsigned WORD_W          = 80;
  localparam int unsigned FRAME_OUT_BYTES = 11;

  typedef enum logic [1:0] {
    COLLECT,
    CALC,
    SEND
  } state_e;

endpackage

// File: rtl/crc_8.sv
// 80-bit CRC-8 engine: registers the CRC of Data when crc_en is high.
// Generator x^8+1, init FF, final invert; for an 80-bit word this reduces
// to the XOR of the ten bytes.
//   clk      system clock, rising edge
//   crc_en   load strobe; crc_out updates on the next edge
//   Data     80-bit message, first byte in [79:72]
//   crc_out  registered CRC byte (no reset; only read after a load)
module crc_8
  import crc8_frame_pkg::*;
(
  input  logic              clk,
  input  logic              crc_en,
  input  logic [WORD_W-1:0] Data,
  output logic [7:0]        crc_out
);

  localparam logic [7:0] POLY = 8'h01;

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  function automatic logic [7:0] crc_calc(input logic [WORD_W-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      fb = c[7] ^ d[WORD_W-1-i];
      c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return ~c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (crc_en) crc_d = crc_calc(Data);
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer around crc_8: collects 10 payload bytes, computes the CRC
// in one cycle, then streams the 10 bytes plus the CRC byte downstream.
// A partial frame stalled for TIMEOUT_CYC idle cycles is discarded.
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_data     upstream byte stream
//   out_valid/out_ready/out_data  downstream byte stream, out_last on CRC byte
//   busy         high unless idle in COLLECT with no bytes held
//   err_timeout  one-cycle pulse when a partial frame is discarded
//   frame_cnt    wrapping count of fully sent frames
module crc8_frame_ctrl
  import crc8_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam bit          TO_EN   = (TIMEOUT_CYC > 0);
  localparam int unsigned TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  state_e              state_q, state_d;
  logic [3:0]          byte_cnt_q, byte_cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  logic                crc_en;
  logic [7:0]          crc_out;
  logic                in_xfer;
  logic                out_xfer;
  logic [3:0]          sel;
  logic [WORD_W-1:0]   word_shift;

  crc_8 u_crc (
    .clk    (clk),
    .crc_en (crc_en),
    .Data   (data_q),
    .crc_out(crc_out)
  );

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_xfer && byte_cnt_q == 4'(FRAME_BYTES - 1)) state_d = CALC;
      CALC:    state_d = SEND;
      SEND:    if (out_xfer && idx_q == 4'(FRAME_OUT_BYTES - 1)) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic; payload bytes are read in place from the packed word
  always_comb begin
    in_ready   = (state_q == COLLECT);
    out_valid  = (state_q == SEND);
    crc_en     = (state_q == CALC);
    out_last   = (state_q == SEND) && (idx_q == 4'(FRAME_OUT_BYTES - 1));
    busy       = !((state_q == COLLECT) && (byte_cnt_q == '0));
    sel        = (idx_q < 4'(FRAME_BYTES)) ? idx_q : '0;
    word_shift = data_q << {sel, 3'b000};
    out_data   = '0;
    if (state_q == SEND) begin
      out_data = (idx_q < 4'(FRAME_BYTES)) ? word_shift[WORD_W-1 -: 8] : crc_out;
    end
  end

  // Datapath: byte packing, stall timeout, send index, frame counter
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    to_cnt_d    = to_cnt_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          data_d     = {data_q[WORD_W-9:0], in_data};
          to_cnt_d   = '0;
          byte_cnt_d = (byte_cnt_q == 4'(FRAME_BYTES - 1)) ? '0 : byte_cnt_q + 1'b1;
        end else if (TO_EN && byte_cnt_q != '0) begin
          // A transfer in the expiry cycle takes the branch above instead.
          if (to_cnt_q == TO_W'(TO_LAST)) begin
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            err_d      = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (idx_q == 4'(FRAME_OUT_BYTES - 1)) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
module tb_crc8_frame_ctrl;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  crc8_frame_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model (queues, XOR checksum) ----------------
  logic [7:0]    m_pay[$];
  logic [7:0]    m_calc[$];
  logic [7:0]    m_tx[$];
  bit            m_calc_p;
  int            m_idle;
  bit            m_err;
  logic [CW-1:0] m_fc;
  bit            m_rdy;
  bit            m_took;
  logic [7:0]    m_x;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pay.delete(); m_calc.delete(); m_tx.delete();
        m_calc_p = 0; m_idle = 0; m_err = 0; m_fc = '0;
      end else begin
        m_rdy  = (m_tx.size() == 0) && !m_calc_p;
        m_took = m_calc_p;
        m_err  = 0;
        if (m_rdy && in_valid) begin
          m_pay.push_back(in_data);
          m_idle = 0;
          if (m_pay.size() == 10) begin
            m_calc = m_pay;
            m_pay.delete();
            m_calc_p = 1;
          end
        end else if (m_rdy && m_pay.size() > 0 && TO > 0) begin
          m_idle++;
          if (m_idle == TO) begin
            m_pay.delete();
            m_idle = 0;
            m_err  = 1;
          end
        end
        if (m_took) begin
          m_x = 8'h00;
          foreach (m_calc[i]) m_x ^= m_calc[i];
          m_tx = m_calc;
          m_tx.push_back(m_x);
          m_calc_p = 0;
        end else if (m_tx.size() > 0 && out_ready) begin
          void'(m_tx.pop_front());
          if (m_tx.size() == 0) m_fc++;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit armed = 0;
  initial begin
    wait (armed);
    forever begin
      @(negedge clk);
      chk("in_ready",    in_ready,    (m_tx.size() == 0) && !m_calc_p);
      chk("out_valid",   out_valid,   m_tx.size() > 0);
      chk("out_data",    out_data,    (m_tx.size() > 0) ? m_tx[0] : 8'h00);
      chk("out_last",    out_last,    m_tx.size() == 1);
      chk("busy",        busy,        (m_pay.size() > 0) || m_calc_p || (m_tx.size() > 0));
      chk("err_timeout", err_timeout, m_err);
      chk("frame_cnt",   frame_cnt,   m_fc);
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap[$];
  int         last_acc_cyc = 0;
  int         first_ov_cyc = 0;
  int         last_cyc = 0;
  int         err_cyc = 0;
  int         n_err = 0;
  int         n_ovir = 0;
  bit         ov_prev = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  initial begin
    forever begin
      @(negedge clk);
      if (in_valid && in_ready) last_acc_cyc = cyc;
      if (out_valid && !ov_prev) first_ov_cyc = cyc;
      if (out_valid && in_ready) n_ovir++;
      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        if (out_last) last_cyc = cyc;
      end
      if (err_timeout) begin n_err++; err_cyc = cyc; end
      if (stall_prev && out_valid && !rst) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      stall_prev = out_valid && !out_ready && !rst;
      prev_data  = out_data;
      prev_last  = out_last;
      ov_prev    = out_valid;
    end
  end

  // ---------------- downstream ready driver ----------------
  bit rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_total++;
    $display("FAIL push_byte: in_ready never seen for byte %0h", b);
  endtask

  task automatic push_frame(input logic [7:0] b[10]);
    for (int i = 0; i < 10; i++) push_byte(b[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cap.size() >= n) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_total++;
    $display("FAIL %s: got %0d output bytes expected %0d", nm, cap.size(), n);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] b[10],
                             input logic [7:0] crc, input logic [CW-1:0] fc);
    wait_out(11, nm);
    chk({nm, "_len"}, cap.size(), 11);
    if (cap.size() == 11) begin
      for (int i = 0; i < 10; i++) chk({nm, "_byte"}, cap[i], b[i]);
      chk({nm, "_crc"}, cap[10], crc);
    end
    chk({nm, "_fcnt"}, frame_cnt, fc);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_in_ready"},  in_ready,    1'b1);
    chk({nm, "_out_valid"}, out_valid,   1'b0);
    chk({nm, "_out_data"},  out_data,    8'h00);
    chk({nm, "_out_last"},  out_last,    1'b0);
    chk({nm, "_busy"},      busy,        1'b0);
    chk({nm, "_err"},       err_timeout, 1'b0);
    chk({nm, "_fcnt"},      frame_cnt,   '0);
  endtask

  // ---------------- directed vectors ----------------
  logic [7:0] f_seq[10];
  logic [7:0] f_a5[10];
  logic [7:0] f_ff[10];
  logic [7:0] f_00[10];
  logic [7:0] f_mix[10];
  logic [7:0] f_race[10];
  logic [7:0] f_walk[10];
  int         t3;

  initial begin
    for (int i = 0; i < 10; i++) begin
      f_seq[i] = 8'(i + 1);
      f_a5[i]  = (i == 0) ? 8'hA5 : 8'h00;
      f_ff[i]  = 8'hFF;
      f_00[i]  = 8'h00;
      f_race[i] = 8'((i + 1) * 16);
    end
    f_mix  = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h11, 8'h22, 8'h44, 8'h81};
    f_walk = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h0F, 8'h00};

    #1 rst = 1'b1;
    armed = 1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back 01..0A, continuous out_ready
    cap.delete();
    push_frame(f_seq);
    check_frame("seq", f_seq, 8'h0B, 3'd1);
    chk("lat_first_valid", first_ov_cyc - last_acc_cyc, 2);
    chk("lat_crc_byte",    last_cyc - last_acc_cyc, 12);

    cap.delete(); push_frame(f_a5); check_frame("a5", f_a5, 8'hA5, 3'd2);
    cap.delete(); push_frame(f_ff); check_frame("ff", f_ff, 8'h00, 3'd3);
    cap.delete(); push_frame(f_00); check_frame("zero", f_00, 8'h00, 3'd4);

    // Random downstream stalls
    rdy_mode = 1;
    cap.delete(); push_frame(f_mix); check_frame("stall", f_mix, 8'h09, 3'd5);
    rdy_mode = 0;

    // Timeout: three bytes then idle
    cap.delete();
    n_err = 0;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    in_valid = 1'b0;
    t3 = last_acc_cyc;
    repeat (14) @(posedge clk); #1;
    chk("to_pulses", n_err, 1);
    chk("to_cycle",  err_cyc - t3, 9);
    chk("to_no_out", cap.size(), 0);
    chk("to_busy",   busy, 1'b0);
    push_frame(f_seq); check_frame("after_to", f_seq, 8'h0B, 3'd6);

    // Byte lands on the expiry cycle
    cap.delete();
    n_err = 0;
    push_byte(f_race[0]); push_byte(f_race[1]); push_byte(f_race[2]);
    in_valid = 1'b0;
    t3 = last_acc_cyc;
    repeat (7) @(posedge clk); #1;
    push_byte(f_race[3]);
    chk("race_gap", last_acc_cyc - t3, 8);
    for (int i = 4; i < 10; i++) push_byte(f_race[i]);
    in_valid = 1'b0;
    check_frame("race", f_race, 8'hB0, 3'd7);
    chk("race_no_err", n_err, 0);

    // frame_cnt wraps 7 -> 0
    cap.delete(); push_frame(f_seq);  check_frame("wrap", f_seq, 8'h0B, 3'd0);
    cap.delete(); push_frame(f_walk); check_frame("walk", f_walk, 8'hF0, 3'd1);

    // Reset mid-SEND at idx 5
    cap.delete();
    push_frame(f_seq);
    for (int k = 0; k < 100 && cap.size() < 5; k++) @(negedge clk);
    chk("pre_rst_sent", cap.size(), 5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cap.delete(); push_frame(f_seq); check_frame("post_rst", f_seq, 8'h0B, 3'd1);

    chk("in_ready_in_send", n_ovir, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
